ysyx_22040386_mem_stage: RTL and testbench
==========================================

# ysyx_22040386_mem_stage

Memory-access stage of the 5-stage pipeline, sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns load/store requests into a req/gnt/rvalid data-memory transaction, extracts and extends load data, and passes ALU results straight through for non-memory instructions. While a transaction is outstanding it stalls upstream stages and feeds a bubble downstream.

## Interface
Parameters:
- none (XLEN fixed at 64, register index fixed at 5 bits)

Ports:
- i_MEM_clk  in  1  clock; all state updates on rising edge.
- i_MEM_rst_n  in  1  reset; asynchronous, active-low.
- i_MEM_valid  in  1  instruction present in EX/MEM.
- i_MEM_RegWrite  in  1  instruction writes rd.
- i_MEM_MemRead  in  1  load.
- i_MEM_MemWrite  in  1  store (never asserted together with MemRead).
- i_MEM_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- i_MEM_reg_wr_addr  in  5  rd.
- i_MEM_alu_result  in  64  effective address, or result for non-memory ops.
- i_MEM_store_data  in  64  rs2 value, LSB-aligned.
- i_MEM_pc  in  64  instruction PC.
- o_MEM_stall  out  1  hold EX/MEM and all earlier stages.
- o_MEM_RegWrite / o_MEM_reg_wr_addr / o_MEM_reg_wr_data / o_MEM_pc  out  1/5/64/64  to MEM/WB.
- o_MEM_misalign  out  1  misaligned access detected this cycle.
- o_dmem_req  out  1  request valid.
- o_dmem_we  out  1  1 = write.
- o_dmem_addr  out  64  doubleword-aligned address ({addr[63:3],3'b0}).
- o_dmem_wdata  out  64  store data shifted to byte lane addr[2:0].
- o_dmem_wmask  out  8  byte enables.
- i_dmem_gnt  in  1  request accepted this cycle.
- i_dmem_rvalid  in  1  read data valid (loads only).
- i_dmem_rdata  in  64  doubleword read data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: non-memory valid instruction -> combinational pass-through (RegWrite, rd, alu_result, pc), stall=0. Memory op, aligned -> latch addr/funct3/rd/pc/wdata/we, stall=1, go REQ. Memory op, misaligned (H: addr[0]≠0, W: addr[1:0]≠0, D: addr[2:0]≠0) -> o_MEM_misalign=1, no request, RegWrite suppressed, stall=0, stay IDLE.
- REQ: o_dmem_req=1, registered outputs from latched values; hold until gnt. gnt on store -> DONE; gnt on load -> WAIT.
- WAIT: req=0; on rvalid capture rdata -> DONE. rvalid in same cycle as gnt is not supported (memory guarantees ≥1 cycle).
- DONE: stall=0; load: o_MEM_RegWrite=latched RegWrite, data = extracted/extended load; store: o_MEM_RegWrite=0. Next state IDLE; upstream advances this cycle.
- Whenever stall=1, o_MEM_RegWrite=0 (bubble into MEM/WB).
- Load extraction: byte lane = rdata >> (8*addr[2:0]); B/H/W sign-extend, BU/HU/WU zero-extend, D unchanged.
- wmask: B 0x01, H 0x03, W 0x0F, D 0xFF, shifted left by addr[2:0].

## Timing
- Reset (async, any state, including mid-transaction): state=IDLE, o_dmem_req=0, latched registers 0; all outputs then follow IDLE rules with i_MEM_valid (0 during reset -> all outputs 0). An in-flight rvalid after reset is ignored.
- Non-memory op: 0-cycle latency, combinational.
- Load with gnt and rvalid at earliest: 4 cycles occupancy (detect, REQ, WAIT, DONE); store: 3 cycles.
- o_dmem_req/we/addr/wdata/wmask remain stable from REQ entry until gnt.
- gnt wait unbounded; rvalid wait unbounded.

## Structure
- Package ysyx_22040386_pkg: funct3 size constants, FSM state typedef (2-bit), XLEN=64.
- Sub-module ysyx_22040386_load_ext: combinational lane select and sign/zero extension (rdata, addr[2:0], funct3 -> 64-bit value).

## Test plan
- ADD result 0x1234, rd=5, RegWrite=1, not memory -> same cycle o_MEM_reg_wr_data=0x1234, rd=5, stall=0.
- LB addr 0x1003, rdata 0x00000000_80000000 with gnt and rvalid on first allowed cycles -> wmask/addr 0x1000, DONE data 0xFFFFFFFF_FFFFFF80, 4-cycle stall window (3 stall cycles).
- SW addr 0x2004, data 0xDEADBEEF, gnt delayed 3 cycles -> wmask 0xF0, wdata 0xDEADBEEF_00000000 held stable, RegWrite=0 throughout.
- LW addr 0x1002 -> o_MEM_misalign=1 for one cycle, o_dmem_req never asserted, RegWrite=0.
- LWU addr 0x3004, rdata 0xFFFFFFFF_00000000 -> DONE data 0x00000000_FFFFFFFF.
- Assert rst_n low while in WAIT, then release -> state IDLE, req=0, following stray rvalid ignored, no RegWrite.

Source files
------------

// File: rtl/ysyx_22040386_pkg.sv
// Shared definitions for the memory-access stage: access sizes, FSM states
// and small helpers for byte-mask generation and alignment checking.
package ysyx_22040386_pkg;

  localparam int unsigned XLEN = 64;

  // funct3 encodings for loads/stores (size in [1:0], unsigned flag in [2])
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } mem_state_e;

  // Byte enables for an access of the given size, before lane shifting
  function automatic logic [7:0] size_mask(input logic [2:0] funct3);
    logic [7:0] m;
    case (funct3[1:0])
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Natural-alignment check on the low address bits
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [2:0] addr_lo);
    logic mis;
    case (funct3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = |addr_lo[1:0];
      default: mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_22040386_load_ext.sv
// Load data extraction: selects the addressed byte lane from a doubleword
// and sign- or zero-extends it according to funct3.
module ysyx_22040386_load_ext
  import ysyx_22040386_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] lane;

  assign lane = rdata >> {addr_lo, 3'b000};

  // Extend the selected lane to XLEN
  always_comb begin
    data = lane;
    case (funct3)
      F3_B:    data = {{56{lane[7]}},  lane[7:0]};
      F3_H:    data = {{48{lane[15]}}, lane[15:0]};
      F3_W:    data = {{32{lane[31]}}, lane[31:0]};
      F3_BU:   data = {56'b0, lane[7:0]};
      F3_HU:   data = {48'b0, lane[15:0]};
      F3_WU:   data = {32'b0, lane[31:0]};
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/ysyx_22040386_mem_stage.sv
// Memory-access pipeline stage. Non-memory instructions pass through
// combinationally; loads/stores run a req/gnt/rvalid transaction while
// stalling upstream and emitting bubbles into MEM/WB.
module ysyx_22040386_mem_stage
  import ysyx_22040386_pkg::*;
(
  input  logic            i_MEM_clk,
  input  logic            i_MEM_rst_n,
  input  logic            i_MEM_valid,
  input  logic            i_MEM_RegWrite,
  input  logic            i_MEM_MemRead,
  input  logic            i_MEM_MemWrite,
  input  logic [2:0]      i_MEM_funct3,
  input  logic [4:0]      i_MEM_reg_wr_addr,
  input  logic [XLEN-1:0] i_MEM_alu_result,
  input  logic [XLEN-1:0] i_MEM_store_data,
  input  logic [XLEN-1:0] i_MEM_pc,
  output logic            o_MEM_stall,
  output logic            o_MEM_RegWrite,
  output logic [4:0]      o_MEM_reg_wr_addr,
  output logic [XLEN-1:0] o_MEM_reg_wr_data,
  output logic [XLEN-1:0] o_MEM_pc,
  output logic            o_MEM_misalign,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [7:0]      o_dmem_wmask,
  input  logic            i_dmem_gnt,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata
);

  mem_state_e      state_q;
  logic            req_q;
  logic            we_q;
  logic            regwrite_q;
  logic [XLEN-1:0] addr_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] wdata_q;
  logic [7:0]      wmask_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] load_data;

  logic mem_op;
  logic misaligned;
  logic mem_start;

  assign mem_op     = i_MEM_valid & (i_MEM_MemRead | i_MEM_MemWrite);
  assign misaligned = is_misaligned(i_MEM_funct3, i_MEM_alu_result[2:0]);
  assign mem_start  = mem_op & ~misaligned;

  ysyx_22040386_load_ext u_load_ext (
    .rdata   (rdata_q),
    .addr_lo (addr_q[2:0]),
    .funct3  (funct3_q),
    .data    (load_data)
  );

  // Transaction FSM; captures the request on entry and the read data on rvalid
  always_ff @(posedge i_MEM_clk or negedge i_MEM_rst_n) begin
    if (!i_MEM_rst_n) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      regwrite_q <= 1'b0;
      addr_q     <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      pc_q       <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_start) begin
            req_q      <= 1'b1;
            we_q       <= i_MEM_MemWrite;
            regwrite_q <= i_MEM_RegWrite;
            addr_q     <= i_MEM_alu_result;
            funct3_q   <= i_MEM_funct3;
            rd_q       <= i_MEM_reg_wr_addr;
            pc_q       <= i_MEM_pc;
            wdata_q    <= i_MEM_store_data << {i_MEM_alu_result[2:0], 3'b000};
            wmask_q    <= size_mask(i_MEM_funct3) << i_MEM_alu_result[2:0];
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_dmem_gnt) begin
            req_q   <= 1'b0;
            state_q <= we_q ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_dmem_rvalid) begin
            rdata_q <= i_dmem_rdata;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_dmem_req   = req_q;
  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = {addr_q[XLEN-1:3], 3'b000};
  assign o_dmem_wdata = wdata_q;
  assign o_dmem_wmask = wmask_q;

  // Stall, misalign and MEM/WB outputs; stalled cycles always carry a bubble
  always_comb begin
    o_MEM_stall       = 1'b0;
    o_MEM_misalign    = 1'b0;
    o_MEM_RegWrite    = 1'b0;
    o_MEM_reg_wr_addr = '0;
    o_MEM_reg_wr_data = '0;
    o_MEM_pc          = '0;
    case (state_q)
      S_IDLE: begin
        if (mem_start) begin
          o_MEM_stall = 1'b1;
        end else if (mem_op) begin
          o_MEM_misalign = 1'b1;
        end else if (i_MEM_valid) begin
          o_MEM_RegWrite    = i_MEM_RegWrite;
          o_MEM_reg_wr_addr = i_MEM_reg_wr_addr;
          o_MEM_reg_wr_data = i_MEM_alu_result;
          o_MEM_pc          = i_MEM_pc;
        end
      end
      S_REQ, S_WAIT: begin
        o_MEM_stall = 1'b1;
      end
      default: begin
        o_MEM_RegWrite    = regwrite_q & ~we_q;
        o_MEM_reg_wr_addr = rd_q;
        o_MEM_reg_wr_data = we_q ? '0 : load_data;
        o_MEM_pc          = pc_q;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_22040386_mem_stage.sv
// Directed bench for the memory-access stage with hand-computed expectations.
module tb_ysyx_22040386_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        valid, regwrite, memread, memwrite;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [63:0] alu, sdata, pc;
  logic        stall, o_rw, misalign, req, we;
  logic [4:0]  o_rd;
  logic [63:0] o_data, o_pc, daddr, wdata;
  logic [7:0]  wmask;
  logic        gnt, rvalid;
  logic [63:0] rdata;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  int unsigned stall_cyc;

  ysyx_22040386_mem_stage dut (
    .i_MEM_clk         (clk),
    .i_MEM_rst_n       (rst_n),
    .i_MEM_valid       (valid),
    .i_MEM_RegWrite    (regwrite),
    .i_MEM_MemRead     (memread),
    .i_MEM_MemWrite    (memwrite),
    .i_MEM_funct3      (funct3),
    .i_MEM_reg_wr_addr (rd),
    .i_MEM_alu_result  (alu),
    .i_MEM_store_data  (sdata),
    .i_MEM_pc          (pc),
    .o_MEM_stall       (stall),
    .o_MEM_RegWrite    (o_rw),
    .o_MEM_reg_wr_addr (o_rd),
    .o_MEM_reg_wr_data (o_data),
    .o_MEM_pc          (o_pc),
    .o_MEM_misalign    (misalign),
    .o_dmem_req        (req),
    .o_dmem_we         (we),
    .o_dmem_addr       (daddr),
    .o_dmem_wdata      (wdata),
    .o_dmem_wmask      (wmask),
    .i_dmem_gnt        (gnt),
    .i_dmem_rvalid     (rvalid),
    .i_dmem_rdata      (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 0; regwrite = 0; memread = 0; memwrite = 0;
    funct3 = 3'b000; rd = 5'd0; alu = '0; sdata = '0; pc = '0;
  endtask

  initial begin
    idle_inputs();
    gnt = 0; rvalid = 0; rdata = '0;
    rst_n = 0;

    // Reset state
    #3;
    chk("rst_stall", {63'b0, stall}, 64'd0);
    chk("rst_req",   {63'b0, req},   64'd0);
    chk("rst_rw",    {63'b0, o_rw},  64'd0);
    chk("rst_data",  o_data,         64'd0);
    chk("rst_addr",  daddr,          64'd0);
    chk("rst_wmask", {56'b0, wmask}, 64'd0);
    tick();
    rst_n = 1;
    tick();

    // ADD: combinational pass-through
    valid = 1; regwrite = 1; rd = 5'd5; alu = 64'h1234; pc = 64'h8000_0000;
    #1;
    chk("add_data",  o_data,         64'h1234);
    chk("add_rd",    {59'b0, o_rd},  64'd5);
    chk("add_rw",    {63'b0, o_rw},  64'd1);
    chk("add_pc",    o_pc,           64'h8000_0000);
    chk("add_stall", {63'b0, stall}, 64'd0);
    chk("add_req",   {63'b0, req},   64'd0);
    tick();

    // LB 0x1003, gnt and rvalid at the earliest cycles
    idle_inputs();
    valid = 1; regwrite = 1; memread = 1; funct3 = 3'b000; rd = 5'd7;
    alu = 64'h1003; pc = 64'h100;
    stall_cyc = 0;
    #1;
    chk("lb_det_stall", {63'b0, stall}, 64'd1);
    chk("lb_det_rw",    {63'b0, o_rw},  64'd0);
    chk("lb_det_req",   {63'b0, req},   64'd0);
    if (stall) stall_cyc++;
    tick();
    chk("lb_req",       {63'b0, req},   64'd1);
    chk("lb_we",        {63'b0, we},    64'd0);
    chk("lb_addr",      daddr,          64'h1000);
    chk("lb_wmask",     {56'b0, wmask}, 64'h08);
    chk("lb_req_rw",    {63'b0, o_rw},  64'd0);
    if (stall) stall_cyc++;
    gnt = 1;
    tick();
    gnt = 0;
    #1;
    chk("lb_wait_req",  {63'b0, req},   64'd0);
    chk("lb_wait_stall",{63'b0, stall}, 64'd1);
    chk("lb_wait_rw",   {63'b0, o_rw},  64'd0);
    if (stall) stall_cyc++;
    rvalid = 1; rdata = 64'h0000_0000_8000_0000;
    tick();
    rvalid = 0; rdata = '0;
    #1;
    chk("lb_done_stall",{63'b0, stall}, 64'd0);
    chk("lb_done_rw",   {63'b0, o_rw},  64'd1);
    chk("lb_done_rd",   {59'b0, o_rd},  64'd7);
    chk("lb_done_data", o_data,         64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_done_pc",   o_pc,           64'h100);
    if (stall) stall_cyc++;
    chk("lb_stall_cycles", 64'(stall_cyc), 64'd3);
    idle_inputs();
    tick();

    // SW 0x2004, gnt delayed 3 cycles
    valid = 1; memwrite = 1; funct3 = 3'b010; alu = 64'h2004;
    sdata = 64'h0000_0000_DEAD_BEEF; pc = 64'h200;
    #1;
    chk("sw_det_stall", {63'b0, stall}, 64'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) gnt = 1;
      #1;
      chk("sw_req",   {63'b0, req},   64'd1);
      chk("sw_we",    {63'b0, we},    64'd1);
      chk("sw_addr",  daddr,          64'h2000);
      chk("sw_wmask", {56'b0, wmask}, 64'hF0);
      chk("sw_wdata", wdata,          64'hDEAD_BEEF_0000_0000);
      chk("sw_rw",    {63'b0, o_rw},  64'd0);
      chk("sw_stall", {63'b0, stall}, 64'd1);
      tick();
    end
    gnt = 0;
    #1;
    chk("sw_done_stall", {63'b0, stall}, 64'd0);
    chk("sw_done_rw",    {63'b0, o_rw},  64'd0);
    chk("sw_done_req",   {63'b0, req},   64'd0);
    idle_inputs();
    tick();

    // LW 0x1002 misaligned
    valid = 1; regwrite = 1; memread = 1; funct3 = 3'b010; rd = 5'd9; alu = 64'h1002;
    #1;
    chk("lw_mis",       {63'b0, misalign}, 64'd1);
    chk("lw_mis_req",   {63'b0, req},      64'd0);
    chk("lw_mis_rw",    {63'b0, o_rw},     64'd0);
    chk("lw_mis_stall", {63'b0, stall},    64'd0);
    tick();
    idle_inputs();
    #1;
    chk("lw_mis_clear", {63'b0, misalign}, 64'd0);
    chk("lw_mis_noreq", {63'b0, req},      64'd0);

    // LH 0x1001 misaligned, byte load at odd address is fine
    valid = 1; memread = 1; funct3 = 3'b001; alu = 64'h1001;
    #1;
    chk("lh_mis", {63'b0, misalign}, 64'd1);
    funct3 = 3'b100;
    #1;
    chk("lbu_odd_ok", {63'b0, misalign}, 64'd0);
    idle_inputs();
    tick();

    // LWU 0x3004
    valid = 1; regwrite = 1; memread = 1; funct3 = 3'b110; rd = 5'd11;
    alu = 64'h3004; pc = 64'h300;
    tick();
    chk("lwu_wmask", {56'b0, wmask}, 64'hF0);
    chk("lwu_addr",  daddr,          64'h3000);
    gnt = 1;
    tick();
    gnt = 0;
    rvalid = 1; rdata = 64'hFFFF_FFFF_0000_0000;
    tick();
    rvalid = 0; rdata = '0;
    #1;
    chk("lwu_data", o_data,        64'h0000_0000_FFFF_FFFF);
    chk("lwu_rw",   {63'b0, o_rw}, 64'd1);
    chk("lwu_rd",   {59'b0, o_rd}, 64'd11);
    idle_inputs();
    tick();

    // LD 0x4000, reset asserted while waiting for rvalid
    valid = 1; regwrite = 1; memread = 1; funct3 = 3'b011; rd = 5'd12;
    alu = 64'h4000; pc = 64'h400;
    tick();
    gnt = 1;
    tick();
    gnt = 0;
    #1;
    chk("rst_wait_stall", {63'b0, stall}, 64'd1);
    idle_inputs();
    #1;
    rst_n = 0;
    #1;
    chk("rst_mid_stall", {63'b0, stall}, 64'd0);
    chk("rst_mid_req",   {63'b0, req},   64'd0);
    chk("rst_mid_addr",  daddr,          64'd0);
    tick();
    rst_n = 1;
    rvalid = 1; rdata = 64'h1111_2222_3333_4444;
    #1;
    chk("stray_stall", {63'b0, stall}, 64'd0);
    chk("stray_rw",    {63'b0, o_rw},  64'd0);
    tick();
    rvalid = 0; rdata = '0;
    #1;
    chk("post_rst_rw",   {63'b0, o_rw},  64'd0);
    chk("post_rst_data", o_data,         64'd0);
    chk("post_rst_req",  {63'b0, req},   64'd0);
    valid = 1; regwrite = 1; rd = 5'd3; alu = 64'h55;
    #1;
    chk("post_rst_add", o_data,        64'h55);
    chk("post_rst_arw", {63'b0, o_rw}, 64'd1);
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
